uart_frame_decoder: RTL

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_defs.sv | 5 +
 rtl/uart_frame_decoder.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_defs.sv
// uart_defs: shared UART frame decoder state and error-cause types
package uart_defs;
   typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_OUT} FrameState_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT} FrameErr_t;
endpackage

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: SOF/LEN/payload/CSUM frame decoder, store-and-forward payload output
module uart_frame_decoder
   import uart_defs::*;
#(
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int          MAX_LEN        = 64,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);
   localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   FrameState_t r_state, w_next;
   FrameErr_t   w_code;
   logic [7:0]  r_len, r_cnt, r_rd_idx, r_sum;
   logic [31:0] r_to;
   logic [7:0]  r_buf [MAX_LEN];
   logic        w_acc, w_hs, w_cnt_en, w_tmo, w_rd_last, w_ok, w_err;
   logic [7:0]  w_sum, w_rd_nxt;
   assign in_ready  = (r_state != ST_OUT);
   assign w_acc     = in_valid && in_ready;
   assign w_hs      = out_valid && out_ready;
   assign w_cnt_en  = r_state inside {ST_LEN, ST_PAYLOAD, ST_CSUM};
   assign w_tmo     = w_cnt_en && !w_acc && (r_to == TIMEOUT_CYCLES - 32'd1);
   assign w_sum     = r_sum + in_data;
   assign w_rd_nxt  = r_rd_idx + 8'd1;
   assign w_rd_last = (r_rd_idx == r_len - 8'd1);
   always_comb begin
      w_next = r_state;
      w_ok   = 1'b0;
      w_err  = 1'b0;
      w_code = ERR_NONE;
      case (r_state)
         ST_IDLE: w_next = (w_acc && in_data == SOF_BYTE) ? ST_LEN : ST_IDLE;
         ST_LEN: if (w_acc) begin
            w_err  = (in_data == 8'd0) || (in_data > MAX_LEN_B);
            w_code = w_err ? ERR_LEN : ERR_NONE;
            w_next = w_err ? ST_IDLE : ST_PAYLOAD;
         end
         ST_PAYLOAD: w_next = (w_acc && r_cnt == r_len - 8'd1) ? ST_CSUM : ST_PAYLOAD;
         ST_CSUM: if (w_acc) begin
            w_ok   = (w_sum == 8'd0);
            w_err  = !w_ok;
            w_code = w_ok ? ERR_NONE : ERR_CSUM;
            w_next = w_ok ? ST_OUT : ST_IDLE;
         end
         ST_OUT: w_next = (w_hs && w_rd_last) ? ST_IDLE : ST_OUT;
         default: w_next = ST_IDLE;
      endcase
      // w_tmo already excludes an accepted byte, so an arriving byte wins
      if (w_tmo) begin
         w_next = ST_IDLE;
         w_err  = 1'b1;
         w_code = ERR_TIMEOUT;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to      <= '0;
         r_len     <= '0;
         r_sum     <= '0;
         r_cnt     <= '0;
         r_rd_idx  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
      end else begin
         r_to      <= (w_acc || !w_cnt_en) ? '0 : r_to + 32'd1;
         frame_ok  <= w_ok;
         frame_err <= w_err;
         if (w_ok || w_err) err_code <= w_code;
         if (r_state == ST_LEN && w_acc) begin
            r_len <= in_data;
            r_sum <= in_data;
            r_cnt <= '0;
         end
         if (r_state == ST_PAYLOAD && w_acc) begin
            r_sum <= w_sum;
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_ok) begin
            r_rd_idx  <= '0;
            out_data  <= r_buf[0];
            out_last  <= (r_len == 8'd1);
            out_valid <= 1'b1;
         end else if (w_hs) begin
            if (w_rd_last) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end else begin
               r_rd_idx <= w_rd_nxt;
               out_data <= r_buf[w_rd_nxt[AW-1:0]];
               out_last <= (w_rd_nxt == r_len - 8'd1);
            end
         end
      end
   end
   always_ff @(posedge clk)
      if (r_state == ST_PAYLOAD && w_acc) r_buf[r_cnt[AW-1:0]] <= in_data;
endmodule
